// File: rtl/address_high_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | address_high_register                                                    |
// | Address-bus-high register with page-cross carry/borrow and fixup cycle.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module address_high_register #(
   parameter int              WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = 8'hFF,
   parameter logic [WIDTH-1:0] STACK_PAGE  = 8'h01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic [WIDTH-1:0] aib_h,
   input  logic             load,
   input  logic             carry_in,
   input  logic             borrow,
   input  logic             fix_en,
   input  logic             inc,
   input  logic             zp_sel,
   input  logic             sp_sel,
   output logic [WIDTH-1:0] abh,
   output logic             fixup_busy,
   output logic             page_cross
);

   localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_zero = '0;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FIXUP = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_abh;
   logic             r_dir;
   logic             r_page_cross;

   logic [WIDTH-1:0] w_aib_adj;
   logic [WIDTH-1:0] w_abh_fix;

   assign w_aib_adj = borrow ? (aib_h - c_one) : (aib_h + c_one);
   assign w_abh_fix = r_dir  ? (r_abh - c_one) : (r_abh + c_one);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_abh        <= RESET_VALUE;
         r_dir        <= 1'b0;
         r_page_cross <= 1'b0;
      end else if (rdy) begin
         case (r_state)
            IDLE: begin
               r_page_cross <= 1'b0;
               if (zp_sel) begin
                  r_abh <= c_zero;
               end else if (sp_sel) begin
                  r_abh <= STACK_PAGE;
               end else if (load && carry_in && fix_en) begin
                  // Uncorrected page goes out first; the carry lands next cycle.
                  r_abh        <= aib_h;
                  r_dir        <= borrow;
                  r_state      <= FIXUP;
                  r_page_cross <= 1'b1;
               end else if (load && carry_in) begin
                  r_abh        <= w_aib_adj;
                  r_page_cross <= 1'b1;
               end else if (load) begin
                  r_abh <= aib_h;
               end else if (inc) begin
                  r_abh        <= r_abh + c_one;
                  r_page_cross <= 1'b1;
               end
            end
            FIXUP: begin
               r_abh        <= w_abh_fix;
               r_page_cross <= 1'b0;
               r_state      <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign abh        = r_abh;
   assign fixup_busy = (r_state == FIXUP);
   assign page_cross = r_page_cross;

endmodule
`default_nettype wire

// File: tb/tb_address_high_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_address_high_register                                                 |
// | Directed bench with a page-arithmetic reference model and literal pins.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_address_high_register;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rdy = 1'b1;
   logic [7:0] aib_h = 8'h00;
   logic       load = 1'b0, carry_in = 1'b0, borrow = 1'b0, fix_en = 1'b0;
   logic       inc = 1'b0, zp_sel = 1'b0, sp_sel = 1'b0;
   logic [7:0] abh;
   logic       fixup_busy, page_cross;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit chk_en    = 1'b0;

   // Reference: page value, a signed pending adjustment (0 = none), pulse flag.
   int m_abh = 255;
   int m_adj = 0;
   bit m_pc  = 1'b0;

   address_high_register dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .aib_h      (aib_h),
      .load       (load),
      .carry_in   (carry_in),
      .borrow     (borrow),
      .fix_en     (fix_en),
      .inc        (inc),
      .zp_sel     (zp_sel),
      .sp_sel     (sp_sel),
      .abh        (abh),
      .fixup_busy (fixup_busy),
      .page_cross (page_cross)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_abh <= 255;
         m_adj <= 0;
         m_pc  <= 1'b0;
      end else if (rdy) begin
         m_pc <= 1'b0;
         if (m_adj != 0) begin
            m_abh <= (m_abh + m_adj + 256) % 256;
            m_adj <= 0;
         end else if (zp_sel) begin
            m_abh <= 0;
         end else if (sp_sel) begin
            m_abh <= 1;
         end else if (load && carry_in) begin
            m_pc <= 1'b1;
            if (fix_en) begin
               m_abh <= int'(aib_h);
               m_adj <= borrow ? -1 : 1;
            end else begin
               m_abh <= (int'(aib_h) + (borrow ? 255 : 1)) % 256;
            end
         end else if (load) begin
            m_abh <= int'(aib_h);
         end else if (inc) begin
            m_abh <= (m_abh + 1) % 256;
            m_pc  <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_abh", abh, 8'(m_abh));
         chk("model_busy", {7'd0, fixup_busy}, {7'd0, (m_adj != 0)});
         chk("model_pc", {7'd0, page_cross}, {7'd0, m_pc});
      end
   end

   task automatic drive(input bit l, input logic [7:0] a, input bit c, input bit b,
                        input bit f, input bit i, input bit z, input bit s);
      load = l; aib_h = a; carry_in = c; borrow = b; fix_en = f;
      inc = i; zp_sel = z; sp_sel = s;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pin(input string name, input logic [7:0] e_abh, input bit e_busy, input bit e_pc);
      chk({name, "_abh"}, abh, e_abh);
      chk({name, "_busy"}, {7'd0, fixup_busy}, {7'd0, e_busy});
      chk({name, "_pc"}, {7'd0, page_cross}, {7'd0, e_pc});
   endtask

   task automatic idle();
      drive(0, 8'h00, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      pin("reset", 8'hFF, 0, 0);

      drive(1, 8'h12, 0, 0, 0, 0, 0, 0); tick(); pin("plain_load", 8'h12, 0, 0);
      idle();                            tick(); pin("hold", 8'h12, 0, 0);

      drive(1, 8'h20, 1, 0, 1, 0, 0, 0); tick(); pin("defer_e1", 8'h20, 1, 1);
      idle();                            tick(); pin("defer_e2", 8'h21, 0, 0);

      drive(1, 8'h20, 1, 0, 1, 0, 0, 0); tick(); pin("defer2_e1", 8'h20, 1, 1);
      drive(1, 8'h55, 0, 0, 0, 0, 1, 0); tick(); pin("defer2_ignore", 8'h21, 0, 0);
      idle();                            tick(); pin("defer2_after", 8'h21, 0, 0);

      drive(1, 8'h00, 1, 1, 0, 0, 0, 0); tick(); pin("borrow_wrap", 8'hFF, 0, 1);
      drive(0, 8'h00, 0, 0, 0, 1, 0, 0); tick(); pin("inc_wrap", 8'h00, 0, 1);
      idle();                            tick(); pin("pc_clear", 8'h00, 0, 0);

      drive(1, 8'h55, 0, 0, 0, 0, 1, 1); tick(); pin("prio_zp", 8'h00, 0, 0);
      drive(1, 8'h55, 0, 0, 0, 0, 0, 1); tick(); pin("prio_sp", 8'h01, 0, 0);
      drive(0, 8'h99, 1, 1, 1, 0, 0, 0); tick(); pin("carry_no_load", 8'h01, 0, 0);

      drive(1, 8'h7F, 1, 1, 1, 0, 0, 0); tick(); pin("stall_enter", 8'h7F, 1, 1);
      idle(); rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(); pin("stall_hold", 8'h7F, 1, 1);
      end
      rdy = 1'b1;                        tick(); pin("stall_release", 8'h7E, 0, 0);

      drive(1, 8'hFF, 1, 0, 0, 0, 0, 0); tick(); pin("carry_wrap", 8'h00, 0, 1);
      drive(1, 8'h00, 1, 1, 1, 0, 0, 0); tick(); pin("dfix_dn_e1", 8'h00, 1, 1);
      idle();                            tick(); pin("dfix_dn_e2", 8'hFF, 0, 0);

      drive(1, 8'h44, 0, 0, 0, 0, 0, 0); rdy = 1'b0;
      tick(); pin("rdy0_idle", 8'hFF, 0, 0);
      rdy = 1'b1;                        tick(); pin("rdy1_load", 8'h44, 0, 0);

      drive(1, 8'h30, 1, 0, 1, 0, 0, 0); tick(); pin("rst_fix_e1", 8'h30, 1, 1);
      idle();
      #2 rst = 1'b1;
      #1 pin("async_rst", 8'hFF, 0, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick(); pin("rst_discard", 8'hFF, 0, 0);

      repeat (2) tick();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
